// File: rtl/gcd_rr_scheduler.sv
// Purpose: shares one GCD engine among N_REQ requesters using round-robin arbitration.
// Latency: accept to RSP_VALID is k+2 cycles (engine DONE k cycles after START); 1 cycle for a zero-operand job.
// Backpressure: one job in flight; REQ_READY only pulses in IDLE, so requests made while BUSY wait there.
module gcd_rr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 511
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [N_REQ-1:0]       REQ_VALID,
  input  logic [N_REQ*WIDTH-1:0] REQ_A,
  input  logic [N_REQ*WIDTH-1:0] REQ_B,
  output logic [N_REQ-1:0]       REQ_READY,
  output logic [N_REQ-1:0]       RSP_VALID,
  output logic [WIDTH-1:0]       RSP_Y,
  output logic                   RSP_ERROR,
  output logic                   BUSY,
  output logic                   ENG_START,
  output logic [WIDTH-1:0]       ENG_A,
  output logic [WIDTH-1:0]       ENG_B,
  input  logic                   ENG_DONE,
  input  logic [WIDTH-1:0]       ENG_Y,
  input  logic                   ENG_ERROR
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   cand;
  logic            found;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic            zero_op;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_inc;
  logic            timeout_hit;

  // Round-robin search: first pending requester at ptr, ptr+1, ... modulo N_REQ.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = PW'((int'(ptr) + i) % N_REQ);
      if (!found && REQ_VALID[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Winner's operands, zero-operand detection and the WAIT timeout comparison.
  always_comb begin
    sel_a       = REQ_A[win_idx*WIDTH +: WIDTH];
    sel_b       = REQ_B[win_idx*WIDTH +: WIDTH];
    zero_op     = (sel_a == '0) || (sel_b == '0);
    count_inc   = count + CW'(1);
    timeout_hit = (count_inc == CW'(TIMEOUT));
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; READY is held low while reset is asserted.
  always_comb begin
    state_nxt = state;
    REQ_READY = '0;
    RSP_VALID = '0;
    ENG_START = 1'b0;
    BUSY      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (found && !RST) begin
          REQ_READY[win_idx] = 1'b1;
          state_nxt          = zero_op ? S_RESP : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        ENG_START = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (ENG_DONE || timeout_hit) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        RSP_VALID[owner] = 1'b1;
        state_nxt        = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Job datapath: operand latch, owner, timeout counter, result capture and pointer update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr       <= '0;
      owner     <= '0;
      count     <= '0;
      ENG_A     <= '0;
      ENG_B     <= '0;
      RSP_Y     <= '0;
      RSP_ERROR <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            ENG_A <= sel_a;
            ENG_B <= sel_b;
            owner <= win_idx;
            if (zero_op) begin
              RSP_Y     <= '0;
              RSP_ERROR <= 1'b1;
            end
          end
        end
        S_LAUNCH: count <= '0;
        S_WAIT: begin
          count <= count_inc;
          // A DONE arriving on the timeout cycle still returns the engine's answer.
          if (ENG_DONE) begin
            RSP_Y     <= ENG_Y;
            RSP_ERROR <= ENG_ERROR;
          end else if (timeout_hit) begin
            RSP_Y     <= '0;
            RSP_ERROR <= 1'b1;
          end
        end
        S_RESP: ptr <= (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Bench for gcd_rr_scheduler: requester agents, a delay-programmable engine model,
// and a round-robin / GCD reference computed from the arbitration rules.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_gcd_rr_scheduler;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 15;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         RST;
  logic [N-1:0] REQ_VALID;
  logic [N*W-1:0] REQ_A, REQ_B;
  logic [N-1:0] REQ_READY, RSP_VALID;
  logic [W-1:0] RSP_Y, ENG_A, ENG_B, ENG_Y;
  logic         RSP_ERROR, BUSY, ENG_START, ENG_DONE, ENG_ERROR;

  gcd_rr_scheduler #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID), .RSP_Y(RSP_Y), .RSP_ERROR(RSP_ERROR),
    .BUSY(BUSY), .ENG_START(ENG_START), .ENG_A(ENG_A), .ENG_B(ENG_B),
    .ENG_DONE(ENG_DONE), .ENG_Y(ENG_Y), .ENG_ERROR(ENG_ERROR)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int mdl_ptr = 0;

  logic [N-1:0] pend;
  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];

  // engine model controls
  bit   eng_active, eng_never, eng_err_cfg, inj_done;
  int   eng_rem, eng_k;
  logic [W-1:0] eng_pa, eng_pb;

  // per-cycle samples
  logic [N-1:0] s_ready, s_rsp_vld, s_vld;
  logic [W-1:0] s_rsp_y, s_eng_a, s_eng_b;
  logic         s_rsp_err, s_start, s_busy;

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y, t;
    x = int'(a);
    y = int'(b);
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int d = 0; d < N; d++)
      if (v[(p + d) % N]) return (p + d) % N;
    return -1;
  endfunction

  // One clock cycle: engine model and requesters drive, then every output is sampled.
  task automatic tick();
    logic dn;
    @(negedge CLK);
    dn = 1'b0;
    ENG_Y = W'($urandom);
    ENG_ERROR = 1'($urandom);
    if (eng_active) begin
      eng_rem--;
      if (eng_rem == 0) begin
        dn = 1'b1;
        eng_active = 1'b0;
        ENG_Y = gcd_ref(eng_pa, eng_pb);
        ENG_ERROR = eng_err_cfg;
      end
    end
    ENG_DONE = dn | inj_done;
    REQ_VALID = pend;
    for (int i = 0; i < N; i++) begin
      REQ_A[i*W +: W] = opa[i];
      REQ_B[i*W +: W] = opb[i];
    end
    #1;
    s_ready = REQ_READY; s_rsp_vld = RSP_VALID; s_rsp_y = RSP_Y; s_rsp_err = RSP_ERROR;
    s_start = ENG_START; s_busy = BUSY; s_eng_a = ENG_A; s_eng_b = ENG_B; s_vld = REQ_VALID;
    if (ENG_START && !eng_never) begin
      eng_active = 1'b1;
      eng_rem = eng_k;
      eng_pa = ENG_A;
      eng_pb = ENG_B;
    end
    for (int i = 0; i < N; i++)
      if (REQ_READY[i] && REQ_VALID[i]) pend[i] = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    pend = '0;
    inj_done = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    eng_active = 1'b0;
    mdl_ptr = 0;
  endtask

  // Ticks until a response appears; reports grant, launch operands, response and latency.
  task automatic run_job(input int budget, output bit got, output int lat, output int gdel,
                         output logic [N-1:0] gvec, output logic [N-1:0] gvld,
                         output logic [N-1:0] rvec, output logic [W-1:0] ry, output logic rerr,
                         output int nstart, output logic [W-1:0] la, output logic [W-1:0] lb);
    int gc, c0;
    gc = -1; c0 = cyc; got = 1'b0; lat = -1; gdel = -1; nstart = 0;
    gvec = '0; gvld = '0; rvec = '0; ry = '0; rerr = 1'b0; la = '0; lb = '0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (s_start) nstart++;
      if (gc < 0 && s_ready != '0) begin
        gc = cyc; gdel = cyc - c0; gvec = s_ready; gvld = s_vld;
      end
      if (gc >= 0 && cyc == gc + 1) begin la = s_eng_a; lb = s_eng_b; end
      if (s_rsp_vld != '0) begin
        got = 1'b1; rvec = s_rsp_vld; ry = s_rsp_y; rerr = s_rsp_err; lat = cyc - gc;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_cmp++; if (s_ready !== '0)    begin n_err++; $display("FAIL reset_ready: got %b want 0", s_ready); end
    n_cmp++; if (s_rsp_vld !== '0)  begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", s_rsp_vld); end
    n_cmp++; if (s_rsp_y !== '0)    begin n_err++; $display("FAIL reset_rsp_y: got %0d want 0", s_rsp_y); end
    n_cmp++; if (s_rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_error: got %b want 0", s_rsp_err); end
    n_cmp++; if (s_start !== 1'b0)  begin n_err++; $display("FAIL reset_eng_start: got %b want 0", s_start); end
    n_cmp++; if (s_eng_a !== '0)    begin n_err++; $display("FAIL reset_eng_a: got %0d want 0", s_eng_a); end
    n_cmp++; if (s_eng_b !== '0)    begin n_err++; $display("FAIL reset_eng_b: got %0d want 0", s_eng_b); end
    n_cmp++; if (s_busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy: got %b want 0", s_busy); end
  endtask

  task automatic test_single();
    bit got; int lat, gdel, ns; logic [N-1:0] gv, gl, rv; logic [W-1:0] ry, la, lb; logic re;
    eng_k = 3; eng_never = 1'b0; eng_err_cfg = 1'b0;
    opa[0] = 8'd48; opb[0] = 8'd18; pend = 4'b0001;
    run_job(60, got, lat, gdel, gv, gl, rv, ry, re, ns, la, lb);
    n_cmp++; if (!got)            begin n_err++; $display("FAIL single_timeout: no response within budget"); end
    n_cmp++; if (gv !== 4'b0001)  begin n_err++; $display("FAIL single_grant: got %b want 0001", gv); end
    n_cmp++; if (la !== 8'd48 || lb !== 8'd18) begin n_err++; $display("FAIL single_eng_ab: got %0d,%0d want 48,18", la, lb); end
    n_cmp++; if (ns != 1)         begin n_err++; $display("FAIL single_start_count: got %0d want 1", ns); end
    n_cmp++; if (rv !== 4'b0001)  begin n_err++; $display("FAIL single_rsp_valid: got %b want 0001", rv); end
    n_cmp++; if (ry !== 8'd6 || re !== 1'b0) begin n_err++; $display("FAIL single_result: got y=%0d err=%b want y=6 err=0", ry, re); end
    n_cmp++; if (lat != eng_k + 2) begin n_err++; $display("FAIL single_latency: got %0d want %0d", lat, eng_k + 2); end
    mdl_ptr = 1;
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    bit got; int lat, gdel, ns, w; logic [N-1:0] gv, gl, rv, ev; logic [W-1:0] ry, la, lb; logic re;
    do_reset();
    eng_k = 5; eng_never = 1'b0; eng_err_cfg = 1'b0;
    for (int i = 0; i < N; i++) begin
      opa[i] = W'($urandom_range(1, 255)); opb[i] = W'($urandom_range(1, 255));
    end
    pend = '1;
    for (int j = 0; j < 5; j++) begin
      run_job(60, got, lat, gdel, gv, gl, rv, ry, re, ns, la, lb);
      w = order[j];
      ev = N'(1) << w;
      n_cmp++; if (!got || gv !== ev) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", j, gv, ev); end
      n_cmp++; if (ry !== gcd_ref(opa[w], opb[w]) || re !== 1'b0 || lat != 7)
        begin n_err++; $display("FAIL rr_result[%0d]: got y=%0d err=%b lat=%0d want y=%0d err=0 lat=7", j, ry, re, lat, gcd_ref(opa[w], opb[w])); end
      pend[w] = 1'b1;
      opa[w] = W'($urandom_range(1, 255)); opb[w] = W'($urandom_range(1, 255));
      mdl_ptr = (w + 1) % N;
    end
  endtask

  task automatic test_zero_operand();
    bit got; int lat, gdel, ns; logic [N-1:0] gv, gl, rv; logic [W-1:0] ry, la, lb; logic re;
    pend = 4'b0100; opa[2] = 8'd0; opb[2] = 8'd9;
    run_job(30, got, lat, gdel, gv, gl, rv, ry, re, ns, la, lb);
    n_cmp++; if (!got || gv !== 4'b0100) begin n_err++; $display("FAIL zero_grant: got %b want 0100", gv); end
    n_cmp++; if (ns != 0)  begin n_err++; $display("FAIL zero_no_start: got %0d starts want 0", ns); end
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL zero_latency: got %0d want 1", lat); end
    n_cmp++; if (rv !== 4'b0100 || ry !== 8'd0 || re !== 1'b1)
      begin n_err++; $display("FAIL zero_rsp: got v=%b y=%0d err=%b want v=0100 y=0 err=1", rv, ry, re); end
    mdl_ptr = 3;
  endtask

  task automatic test_timeout();
    bit got; int lat, gdel, ns; logic [N-1:0] gv, gl, rv; logic [W-1:0] ry, la, lb; logic re;
    eng_never = 1'b1;
    pend = 4'b0010; opa[1] = 8'd12; opb[1] = 8'd8;
    run_job(60, got, lat, gdel, gv, gl, rv, ry, re, ns, la, lb);
    n_cmp++; if (!got || rv !== 4'b0010) begin n_err++; $display("FAIL timeout_rsp_valid: got %b want 0010", rv); end
    n_cmp++; if (lat != TO + 2) begin n_err++; $display("FAIL timeout_latency: got %0d want %0d", lat, TO + 2); end
    n_cmp++; if (ry !== 8'd0 || re !== 1'b1) begin n_err++; $display("FAIL timeout_result: got y=%0d err=%b want y=0 err=1", ry, re); end
    eng_never = 1'b0; eng_k = 2; eng_err_cfg = 1'b0;
    pend = 4'b1000; opa[3] = 8'd35; opb[3] = 8'd21;
    run_job(60, got, lat, gdel, gv, gl, rv, ry, re, ns, la, lb);
    n_cmp++; if (!got || rv !== 4'b1000 || ry !== 8'd7 || re !== 1'b0 || lat != 4)
      begin n_err++; $display("FAIL after_timeout_job: got v=%b y=%0d err=%b lat=%0d want v=1000 y=7 err=0 lat=4", rv, ry, re, lat); end
    mdl_ptr = 0;
  endtask

  task automatic test_done_on_timeout();
    bit got; int lat, gdel, ns, bad; logic [N-1:0] gv, gl, rv; logic [W-1:0] ry, la, lb; logic re;
    eng_never = 1'b0; eng_k = TO;
    for (int e = 0; e < 2; e++) begin
      eng_err_cfg = 1'(e);
      pend = 4'b0001; opa[0] = 8'd100; opb[0] = 8'd75;
      run_job(60, got, lat, gdel, gv, gl, rv, ry, re, ns, la, lb);
      n_cmp++; if (!got || ry !== 8'd25 || re !== 1'(e) || lat != TO + 2)
        begin n_err++; $display("FAIL done_on_timeout[%0d]: got y=%0d err=%b lat=%0d want y=25 err=%0d lat=%0d", e, ry, re, lat, e, TO + 2); end
    end
    mdl_ptr = 1;
    bad = 0;
    inj_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (s_busy !== 1'b0 || s_rsp_vld !== '0 || s_start !== 1'b0) bad++;
    end
    inj_done = 1'b0;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL done_in_idle: got %0d disturbed cycles want 0", bad); end
  endtask

  task automatic test_random();
    bit got; int lat, gdel, ns, w; logic [N-1:0] gv, gl, rv, ev; logic [W-1:0] ry, la, lb, ey; logic re, ee, z;
    int bad = 0;
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          opa[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(1, 255));
          opb[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(1, 255));
        end
      if (pend == '0) begin
        w = $urandom_range(0, N - 1); pend[w] = 1'b1;
        opa[w] = W'($urandom_range(1, 255)); opb[w] = W'($urandom_range(1, 255));
      end
      eng_k = $urandom_range(1, 8); eng_err_cfg = 1'($urandom);
      run_job(60, got, lat, gdel, gv, gl, rv, ry, re, ns, la, lb);
      w = rr_pick(gl, mdl_ptr);
      ev = (w < 0) ? '0 : (N'(1) << w);
      if (w < 0) w = 0;
      z = (opa[w] == 0) || (opb[w] == 0);
      ey = z ? 8'd0 : gcd_ref(opa[w], opb[w]);
      ee = z ? 1'b1 : eng_err_cfg;
      n_cmp++;
      if (!got || gdel != 1 || gv !== ev || rv !== ev || ry !== ey || re !== ee || lat != (z ? 1 : eng_k + 2)) begin
        n_err++; bad++;
        if (bad < 6)
          $display("FAIL random_job[%0d]: got grant=%b rsp=%b y=%0d err=%b lat=%0d gdel=%0d want grant=%b y=%0d err=%b lat=%0d gdel=1",
                   j, gv, rv, ry, re, lat, gdel, ev, ey, ee, z ? 1 : eng_k + 2);
      end
      mdl_ptr = (w + 1) % N;
    end
  endtask

  task automatic test_reset_mid_job();
    bit got; int lat, gdel, ns, stray; logic [N-1:0] gv, gl, rv; logic [W-1:0] ry, la, lb; logic re;
    do_reset();
    eng_never = 1'b0; eng_k = 2; eng_err_cfg = 1'b0;
    pend = 4'b0010; opa[1] = 8'd9; opb[1] = 8'd6;
    run_job(30, got, lat, gdel, gv, gl, rv, ry, re, ns, la, lb);
    n_cmp++; if (!got || ry !== 8'd3) begin n_err++; $display("FAIL pre_reset_job: got y=%0d want 3", ry); end
    eng_never = 1'b1;
    pend = 4'b0100; opa[2] = 8'd40; opb[2] = 8'd30;
    for (int i = 0; i < 6; i++) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    eng_active = 1'b0;
    tick();
    n_cmp++; if (s_busy !== 1'b0 || s_ready !== '0 || s_rsp_vld !== '0 || s_start !== 1'b0)
      begin n_err++; $display("FAIL midreset_ctrl: got busy=%b ready=%b rsp=%b start=%b want all 0", s_busy, s_ready, s_rsp_vld, s_start); end
    n_cmp++; if (s_eng_a !== '0 || s_eng_b !== '0 || s_rsp_y !== '0 || s_rsp_err !== 1'b0)
      begin n_err++; $display("FAIL midreset_data: got a=%0d b=%0d y=%0d err=%b want all 0", s_eng_a, s_eng_b, s_rsp_y, s_rsp_err); end
    stray = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (s_rsp_vld !== '0) stray++;
    end
    n_cmp++; if (stray != 0) begin n_err++; $display("FAIL midreset_no_rsp: got %0d response cycles want 0", stray); end
    eng_never = 1'b0; eng_k = 1;
    for (int i = 0; i < N; i++) begin opa[i] = 8'd14; opb[i] = 8'd21; end
    pend = '1;
    run_job(30, got, lat, gdel, gv, gl, rv, ry, re, ns, la, lb);
    n_cmp++; if (!got || gv !== 4'b0001 || ry !== 8'd7 || lat != 3)
      begin n_err++; $display("FAIL midreset_ptr: got grant=%b y=%0d lat=%0d want grant=0001 y=7 lat=3", gv, ry, lat); end
  endtask

  initial begin
    RST = 1'b1; REQ_VALID = '0; REQ_A = '0; REQ_B = '0;
    ENG_DONE = 1'b0; ENG_Y = '0; ENG_ERROR = 1'b0;
    pend = '0; eng_active = 1'b0; eng_never = 1'b0; eng_err_cfg = 1'b0; inj_done = 1'b0;
    eng_k = 1; eng_rem = 0; eng_pa = '0; eng_pb = '0;
    for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
    test_reset();
    test_single();
    test_round_robin();
    test_zero_operand();
    test_timeout();
    test_done_on_timeout();
    test_random();
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
